// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer and its ALU.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;

  // Sequencer states; the encoding is exported on the debug LEDs.
  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_SHOW    = 3'd5
  } state_t;

  // Opcodes understood by the ALU; anything else yields a zero result.
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT = 4'd6;
  localparam logic [OP_W-1:0] OP_INC = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR = 4'd9;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_op_sequencer_edge_detect_rise.sv
// Single-cycle rising-edge pulse from a level input (already synchronised
// and debounced upstream).
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic r_in_d;

  // Remember the previous level so a held level counts as one edge.
  // NOTE: reset is sampled only on the clock edge (synchronous), so rst_n is
  // deliberately absent from the sensitivity list; state uses <= so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_d <= 1'b0;
    end else begin
      r_in_d <= in;
    end
  end

  assign rise = in & ~r_in_d;

endmodule : edge_detect_rise

// File: rtl/alu_op_sequencer.sv
// Operand/opcode collector and result capture stage wrapped around the
// combinational 8-bit ALU. One button press per field: A, B, opcode; then a
// timed start strobe, a settle window, and a registered result for display.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int START_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              clear,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [OP_W-1:0]   op_o,
  output logic              start_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  output logic [DATA_W-1:0] result_q,
  output logic [FLAG_W-1:0] flags_q,
  output logic              done,
  output logic              busy,
  output logic [2:0]        state_o,
  output logic [7:0]        op_count
);

  // One shared down-counter serves both the start and the settle windows.
  localparam int CNT_MAX = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_op;
  logic                r_start;
  logic [DATA_W-1:0]   r_result;
  logic [FLAG_W-1:0]   r_flags;
  logic                r_done;
  logic                r_busy;
  logic [7:0]          r_op_count;
  logic                w_load_rise;

  edge_detect_rise u_load_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (load),
    .rise  (w_load_rise)
  );

  // Sequencer: field capture, start/settle timing and result capture, with
  // every output registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_GET_A;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_start    <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_op_count <= '0;
    end else if (clear) begin
      // Abort to the first field; operands and captured results are kept.
      r_state <= ST_GET_A;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_GET_A: begin
          if (w_load_rise) begin
            r_a     <= data_in;
            r_state <= ST_GET_B;
          end
        end
        ST_GET_B: begin
          if (w_load_rise) begin
            r_b     <= data_in;
            r_state <= ST_GET_OP;
          end
        end
        ST_GET_OP: begin
          // Start goes high together with the EXEC state so the strobe
          // covers exactly the EXEC cycles.
          if (w_load_rise) begin
            r_op    <= data_in[OP_W-1:0];
            r_cnt   <= '0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == START_LAST) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_result   <= alu_result_i;
            r_flags    <= alu_flags_i;
            r_op_count <= r_op_count + 8'd1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_SHOW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          // The press that leaves SHOW only acknowledges; it loads nothing.
          if (w_load_rise) begin
            r_done  <= 1'b0;
            r_state <= ST_GET_A;
          end
        end
        default: begin
          r_state <= ST_GET_A;
          r_cnt   <= '0;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign a_o      = r_a;
  assign b_o      = r_b;
  assign op_o     = r_op;
  assign start_o  = r_start;
  assign result_q = r_result;
  assign flags_q  = r_flags;
  assign done     = r_done;
  assign busy     = r_busy;
  assign state_o  = r_state;
  assign op_count = r_op_count;

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a stub ALU closes the loop,
// expected results are queued when an operation is issued and compared
// when done rises.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        load;
  logic        clear;
  logic [7:0]  a_o, b_o;
  logic [3:0]  op_o;
  logic        start_o;
  logic [7:0]  alu_result_i;
  logic [3:0]  alu_flags_i;
  logic [7:0]  result_q;
  logic [3:0]  flags_q;
  logic        done, busy;
  logic [2:0]  state_o;
  logic [7:0]  op_count;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flags;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_bus;
    logic [3:0] exp_op;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[10];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_count = 8'd0;
  logic [7:0] last_res  = 8'd0;
  logic [3:0] last_flags = 4'd0;

  always #5 clk = ~clk;

  // Reference ALU used as the stub; flags are {N,Z,C,V}.
  function automatic logic [11:0] alu_stub(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                    v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                    v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_INC: begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; v = (a == 8'h7F); end
      OP_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = 8'h00;
    endcase
    return {r, r[7], (r == 8'h00), c, v};
  endfunction

  assign {alu_result_i, alu_flags_i} = alu_stub(a_o, b_o, op_o);

  alu_op_sequencer #(.START_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .load         (load),
    .clear        (clear),
    .a_o          (a_o),
    .b_o          (b_o),
    .op_o         (op_o),
    .start_o      (start_o),
    .alu_result_i (alu_result_i),
    .alu_flags_i  (alu_flags_i),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .done         (done),
    .busy         (busy),
    .state_o      (state_o),
    .op_count     (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    tick();
  endtask

  // Final field press: returns one cycle after the edge that enters EXEC.
  task automatic issue_op(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_o"},      32'(a_o),      32'h0);
    check({tag, ".b_o"},      32'(b_o),      32'h0);
    check({tag, ".op_o"},     32'(op_o),     32'h0);
    check({tag, ".start_o"},  32'(start_o),  32'h0);
    check({tag, ".result_q"}, 32'(result_q), 32'h0);
    check({tag, ".flags_q"},  32'(flags_q),  32'h0);
    check({tag, ".done"},     32'(done),     32'h0);
    check({tag, ".busy"},     32'(busy),     32'h0);
    check({tag, ".state"},    32'(state_o),  32'(ST_GET_A));
    check({tag, ".op_count"}, 32'(op_count), 32'h0);
  endtask

  // Waits (bounded) for done, measures start width, optionally presses the
  // button in cycle 'poke' after entering EXEC, then pops the scoreboard.
  task automatic finish_op(input int poke, input string tag);
    int   n_start;
    bit   seen;
    exp_t e;
    n_start = 0;
    seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == poke) load = 1'b1;
      if (start_o) n_start++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (poke >= 0) begin
      load = 1'b0;
      tick();
    end
    check({tag, ".done_seen"},   32'(seen),    32'h1);
    check({tag, ".start_width"}, 32'(n_start), 32'd2);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_nonempty"}, 32'h0, 32'h1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".result_q"}, 32'(result_q), 32'(e.res));
      check({tag, ".flags_q"},  32'(flags_q),  32'(e.flags));
      check({tag, ".op_count"}, 32'(op_count), 32'(e.cnt));
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_bus,
                        input logic [3:0] exp_op, input logic [7:0] exp_res,
                        input logic [3:0] exp_flags, input int hold, input int poke,
                        input string tag);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.res = exp_res; e.flags = exp_flags; e.cnt = exp_count;
    sb_q.push_back(e);
    if (hold > 0) begin
      data_in = a;
      load    = 1'b1;
      repeat (hold) tick();
      check({tag, ".hold_a"},     32'(a_o),     32'(a));
      check({tag, ".hold_state"}, 32'(state_o), 32'(ST_GET_B));
      load = 1'b0;
      tick();
      check({tag, ".hold_stay"},  32'(state_o), 32'(ST_GET_B));
    end else begin
      press(a);
    end
    press(b);
    issue_op(op_bus);
    check({tag, ".exec_busy"}, 32'(busy), 32'h1);
    finish_op(poke, tag);
    check({tag, ".op_o"}, 32'(op_o), 32'(exp_op));
    check({tag, ".a_o"},  32'(a_o),  32'(a));
    check({tag, ".b_o"},  32'(b_o),  32'(b));
    press(8'hC3);
    check({tag, ".ack_state"}, 32'(state_o), 32'(ST_GET_A));
    check({tag, ".ack_done"},  32'(done),    32'h0);
    check({tag, ".ack_a_o"},   32'(a_o),     32'(a));
    last_res   = exp_res;
    last_flags = exp_flags;
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h01, 4'h1, 8'h08, 4'b0000};
    vecs[1] = '{8'h7F, 8'h01, 8'h01, 4'h1, 8'h80, 4'b1001};
    vecs[2] = '{8'hFF, 8'h01, 8'h01, 4'h1, 8'h00, 4'b0110};
    vecs[3] = '{8'h03, 8'h05, 8'h02, 4'h2, 8'hFE, 4'b1010};
    vecs[4] = '{8'hF0, 8'h3C, 8'h03, 4'h3, 8'h30, 4'b0000};
    vecs[5] = '{8'h0F, 8'hF0, 8'h04, 4'h4, 8'hFF, 4'b1000};
    vecs[6] = '{8'hAA, 8'hAA, 8'h05, 4'h5, 8'h00, 4'b0100};
    vecs[7] = '{8'h81, 8'h00, 8'h08, 4'h8, 8'h02, 4'b0010};
    vecs[8] = '{8'h81, 8'h00, 8'h09, 4'h9, 8'h40, 4'b0010};
    vecs[9] = '{8'h12, 8'h34, 8'hAF, 4'hF, 8'h00, 4'b0100};

    rst_n = 1'b0; load = 1'b0; clear = 1'b0; data_in = 8'h00;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Table-driven operations; the first one is the basic 5+3 case.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op_bus, vecs[i].exp_op,
             vecs[i].exp_res, vecs[i].exp_flags, 0, -1, $sformatf("vec%0d", i));
    end

    // Held button in GET_A: one advance only.
    run_op(8'h7F, 8'h01, 8'h01, 4'h1, 8'h80, 4'b1001, 10, -1, "hold");

    // Presses during EXEC and during SETTLE are ignored.
    run_op(8'h21, 8'h10, 8'h02, 4'h2, 8'h11, 4'b0000, 0, 1, "poke_exec");
    run_op(8'h40, 8'h40, 8'h01, 4'h1, 8'h80, 4'b1001, 0, 2, "poke_settle");

    // Clear in SETTLE: abort before capture, previous results kept.
    press(8'h10);
    press(8'h20);
    issue_op(8'h01);
    tick();
    tick();
    check("clr.pre_state", 32'(state_o), 32'(ST_SETTLE));
    check("clr.pre_busy",  32'(busy),    32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.state",    32'(state_o),  32'(ST_GET_A));
    check("clr.busy",     32'(busy),     32'h0);
    check("clr.done",     32'(done),     32'h0);
    check("clr.start",    32'(start_o),  32'h0);
    check("clr.result_q", 32'(result_q), 32'(last_res));
    check("clr.flags_q",  32'(flags_q),  32'(last_flags));
    check("clr.op_count", 32'(op_count), 32'(exp_count));

    // Clear and a load edge together: clear wins, A is not loaded.
    data_in = 8'h99;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    check("clr_load.state", 32'(state_o), 32'(ST_GET_A));
    check("clr_load.a_o",   32'(a_o),     32'h10);
    load  = 1'b0;
    clear = 1'b0;
    tick();
    run_op(8'h06, 8'h00, 8'h06, 4'h6, 8'hF9, 4'b1000, 0, -1, "after_clr");

    // Reset while start is high.
    press(8'h11);
    press(8'h22);
    issue_op(8'h02);
    check("rst_exec.start_pre", 32'(start_o), 32'h1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rst_exec");
    rst_n = 1'b1;
    tick();
    exp_count = 8'd0;

    // 256 operations: the completed-operation counter wraps to zero.
    for (int i = 0; i < 256; i++) begin
      logic [11:0] x;
      x = alu_stub(8'(i), 8'h01, OP_ADD);
      run_op(8'(i), 8'h01, 8'h01, 4'h1, x[11:4], x[3:0], 0, -1, $sformatf("wrap%0d", i));
    end
    check("wrap.op_count", 32'(op_count), 32'h0);
    check("sb.empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_alu_op_sequencer
